// File: rtl/universal_shift_register_nbit.sv
// universal_shift_register_nbit
// N-bit operand register: single-cycle HOLD/LOAD/CLEAR and multi-cycle
// SHL/SHR/ROL/ROR/ASR run by a two-state FSM under a start/busy/done handshake.
// Optional build macro: USR_OVERFLOW_EN adds the sticky 'ovf' output.
module universal_shift_register_nbit #(
  parameter int unsigned N = 8,
  parameter logic [N-1:0] RESET_VAL = '0,
  localparam int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [N-1:0]     I,
  input  logic             sin,
  output logic [N-1:0]     Q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef USR_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e              sh_op_c;
  logic [N-1:0]     sh_q_c;
  logic             sh_out_c;
  logic [CNT_W-1:0] m_c;
  logic             is_shift_c;

`ifdef USR_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             sh_ovf_c;
`endif

  // Operation in effect: the incoming op while idle, the latched op while shifting
  assign sh_op_c    = (state_q == ST_IDLE) ? op_e'(op) : op_q;
  // Requested shift count clamped to the register width
  assign m_c        = (amt > CNT_W'(N)) ? CNT_W'(N) : amt;
  assign is_shift_c = (op_e'(op) inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});

  // One-bit shift/rotate of the current contents and the bit that leaves
  always_comb begin
    sh_q_c   = q_q;
    sh_out_c = sout_q;
    case (sh_op_c)
      OP_SHL: begin sh_q_c = {q_q[N-2:0], sin};     sh_out_c = q_q[N-1]; end
      OP_SHR: begin sh_q_c = {sin, q_q[N-1:1]};     sh_out_c = q_q[0];   end
      OP_ROL: begin sh_q_c = {q_q[N-2:0], q_q[N-1]}; sh_out_c = q_q[N-1]; end
      OP_ROR: begin sh_q_c = {q_q[0], q_q[N-1:1]};   sh_out_c = q_q[0];   end
      OP_ASR: begin sh_q_c = {q_q[N-1], q_q[N-1:1]}; sh_out_c = q_q[0];   end
      default: ;
    endcase
  end

`ifdef USR_OVERFLOW_EN
  // Rotates recirculate their bit, so only true shifts can lose a 1
  assign sh_ovf_c = sh_out_c & (sh_op_c inside {OP_SHL, OP_SHR, OP_ASR});
`endif

  // Next-state and next-output logic; en=0 freezes everything and drops done
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef USR_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d = op_e'(op);
`ifdef USR_OVERFLOW_EN
            ovf_d = 1'b0;
`endif
            case (op_e'(op))
              OP_LOAD:  q_d = I;
              OP_CLEAR: q_d = '0;
              OP_HOLD:  ;
              default: begin
                if (m_c != '0) begin
                  q_d    = sh_q_c;
                  sout_d = sh_out_c;
                  cnt_d  = m_c - CNT_W'(1);
`ifdef USR_OVERFLOW_EN
                  ovf_d  = sh_ovf_c;
`endif
                end
              end
            endcase
            if (is_shift_c && (m_c > CNT_W'(1))) begin
              busy_d  = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              done_d  = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          q_d    = sh_q_c;
          sout_d = sh_out_c;
          cnt_d  = cnt_q - CNT_W'(1);
`ifdef USR_OVERFLOW_EN
          ovf_d  = ovf_q | sh_ovf_c;
`endif
          if (cnt_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef USR_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef USR_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef USR_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_universal_shift_register_nbit.sv
// Bench for universal_shift_register_nbit (N=8): constant vector table,
// hand-written stall/reset/busy sequences, then random ops against an
// arithmetic reference model.
module tb_universal_shift_register_nbit;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [N-1:0] RST_V = 8'h00;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [N-1:0]     I;
  logic             sin;
  logic [N-1:0]     Q;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef USR_OVERFLOW_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0] mq    = RST_V;
  logic         msout = 1'b0;
  logic         mbusy = 1'b0;
  logic         movf  = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register_nbit #(.N(N), .RESET_VAL(RST_V)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .op    (op),
    .amt   (amt),
    .I     (I),
    .sin   (sin),
    .Q     (Q),
    .sout  (sout),
    .busy  (busy),
`ifdef USR_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  typedef struct {
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [N-1:0]     pre;
    logic [N-1:0]     d;
    logic             sin;
    logic [N-1:0]     exp_q;
    logic             sout_ck;
    logic             exp_sout;
    int               exp_cyc;
    logic             exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef USR_OVERFLOW_EN
    chk(name, 32'(ovf), 32'(exp));
`else
    if (exp === 1'bz) $display("unreachable %s", name);
`endif
  endtask

  // One shift step computed with plain integer arithmetic
  task automatic model_shift(input logic [2:0] o, input logic s);
    int v, top, full, outb;
    v    = int'(mq);
    top  = 1 << (N - 1);
    full = 1 << N;
    outb = 0;
    case (o)
      OP_SHL: begin outb = v / top;  v = (v * 2) % full + int'(s); end
      OP_SHR: begin outb = v % 2;    v = v / 2 + int'(s) * top; end
      OP_ROL: begin outb = v / top;  v = (v * 2) % full + outb; end
      OP_ROR: begin outb = v % 2;    v = v / 2 + outb * top; end
      OP_ASR: begin outb = v % 2;    v = v / 2 + ((v >= top) ? top : 0); end
      default: ;
    endcase
    mq    = N'(v);
    msout = (outb != 0);
    if (outb != 0 && (o == OP_SHL || o == OP_SHR || o == OP_ASR)) movf = 1'b1;
  endtask

  // Issue one op and check every cycle against the model; optional en stalls
  task automatic run_op(input logic [2:0] o, input int a, input logic [N-1:0] d, input bit stalls);
    int m, edges;
    bit sh;
    m     = (a > N) ? N : a;
    sh    = (o >= OP_SHL) && (o <= OP_ASR);
    edges = (sh && m > 0) ? m : 1;
    op = o; amt = CNT_W'(a); I = d; start = 1'b1; en = 1'b1;
    for (int t = 1; t <= edges; t++) begin
      if (stalls && $urandom_range(0, 3) == 0) begin
        en = 1'b0;
        step();
        chk("stall_q", 32'(Q), 32'(mq));
        chk("stall_done", 32'(done), 32'(0));
        chk("stall_busy", 32'(busy), 32'(mbusy));
        en = 1'b1;
      end
      sin = 1'($urandom);
      if (t == 1) begin
        movf = 1'b0;
        if (o == OP_LOAD)  mq = d;
        if (o == OP_CLEAR) mq = '0;
      end
      if (sh && m > 0) model_shift(o, sin);
      mbusy = (t < edges);
      step();
      chk("op_q", 32'(Q), 32'(mq));
      chk("op_sout", 32'(sout), 32'(msout));
      chk("op_busy", 32'(busy), 32'(mbusy));
      chk("op_done", 32'(done), 32'(t == edges));
      chk_ovf("op_ovf", movf);
      start = 1'($urandom);
      op    = 3'($urandom);
      amt   = CNT_W'($urandom);
      I     = N'($urandom);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    int   cyc;
    bit   saw_busy;

    vt[0]  = '{OP_LOAD,  4'd0,  8'h3C, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1, 1'b0};
    vt[1]  = '{OP_SHL,   4'd3,  8'h81, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b0, 3, 1'b1};
    vt[2]  = '{OP_ROR,   4'd9,  8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 8, 1'b0};
    vt[3]  = '{OP_SHR,   4'd1,  8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b1, 1, 1'b1};
    vt[4]  = '{OP_SHR,   4'd0,  8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0};
    vt[5]  = '{OP_ASR,   4'd2,  8'h80, 8'h00, 1'b0, 8'hE0, 1'b1, 1'b0, 2, 1'b0};
    vt[6]  = '{OP_ROL,   4'd4,  8'h81, 8'h00, 1'b0, 8'h18, 1'b1, 1'b0, 4, 1'b0};
    vt[7]  = '{OP_CLEAR, 4'd0,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0};
    vt[8]  = '{OP_HOLD,  4'd5,  8'h77, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0, 1, 1'b0};
    vt[9]  = '{OP_SHL,   4'd8,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8, 1'b1};
    vt[10] = '{OP_ASR,   4'd7,  8'h40, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 7, 1'b1};
    vt[11] = '{OP_SHR,   4'd8,  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8, 1'b0};
    vt[12] = '{OP_ROL,   4'd15, 8'hC3, 8'h00, 1'b0, 8'hC3, 1'b1, 1'b1, 8, 1'b0};

    reset = 1'b1; en = 1'b0; start = 1'b0; op = OP_HOLD; amt = '0; I = '0; sin = 1'b0;
    #12;
    chk("rst_q", 32'(Q), 32'(RST_V));
    chk("rst_sout", 32'(sout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk_ovf("rst_ovf", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;

    // Constant vector table: preload, run, count edges to done
    for (int k = 0; k < 13; k++) begin
      run_op(OP_LOAD, 0, vt[k].pre, 1'b0);
      op = vt[k].op; amt = vt[k].amt; I = vt[k].d; sin = vt[k].sin; start = 1'b1; en = 1'b1;
      cyc = 0; saw_busy = 1'b0;
      do begin
        step();
        start = 1'b0;
        cyc++;
        if (busy) saw_busy = 1'b1;
      end while (!done && cyc < 40);
      chk($sformatf("vec%0d_cycles", k), 32'(cyc), 32'(vt[k].exp_cyc));
      chk($sformatf("vec%0d_q", k), 32'(Q), 32'(vt[k].exp_q));
      chk($sformatf("vec%0d_sout", k), 32'(sout), 32'(vt[k].sout_ck ? vt[k].exp_sout : msout));
      chk($sformatf("vec%0d_busy_seen", k), 32'(saw_busy), 32'(vt[k].exp_cyc > 1));
      chk_ovf($sformatf("vec%0d_ovf", k), vt[k].exp_ovf);
      mq = vt[k].exp_q;
      if (vt[k].sout_ck) msout = vt[k].exp_sout;
      mbusy = 1'b0;
      movf = vt[k].exp_ovf;
    end

    // ASR with a two-cycle enable stall after the first shift
    run_op(OP_LOAD, 0, 8'h80, 1'b0);
    op = OP_ASR; amt = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("asr_first_q", 32'(Q), 32'(8'hC0));
    chk("asr_first_busy", 32'(busy), 32'(1));
    en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      chk("asr_stall_q", 32'(Q), 32'(8'hC0));
      chk("asr_stall_done", 32'(done), 32'(0));
    end
    en = 1'b1;
    step();
    chk("asr_final_q", 32'(Q), 32'(8'hE0));
    chk("asr_final_done", 32'(done), 32'(1));
    chk("asr_final_busy", 32'(busy), 32'(0));
    mq = 8'hE0; msout = 1'b0; mbusy = 1'b0; movf = 1'b0;

    // Asynchronous reset between edges in the middle of a SHL
    run_op(OP_LOAD, 0, 8'h3C, 1'b0);
    op = OP_SHL; amt = 4'd5; sin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_shl_q", 32'(Q), 32'(8'h78));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_q", 32'(Q), 32'(RST_V));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    #1 reset = 1'b0;
    mq = RST_V; msout = 1'b0; mbusy = 1'b0; movf = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("post_rst_q", 32'(Q), 32'(RST_V));
      chk("post_rst_done", 32'(done), 32'(0));
    end
    run_op(OP_LOAD, 0, 8'h5A, 1'b0);

    // start while busy is ignored; amt=0 shift completes at once
    run_op(OP_LOAD, 0, 8'h11, 1'b0);
    op = OP_SHL; amt = 4'd3; sin = 1'b0; start = 1'b1;
    step();
    chk("busy_ign_q1", 32'(Q), 32'(8'h22));
    op = OP_SHL; amt = 4'd1; sin = 1'b0; start = 1'b1;
    step();
    chk("busy_ign_q2", 32'(Q), 32'(8'h44));
    chk("busy_ign_busy", 32'(busy), 32'(1));
    step();
    start = 1'b0;
    chk("busy_ign_q3", 32'(Q), 32'(8'h88));
    chk("busy_ign_done", 32'(done), 32'(1));
    mq = 8'h88; msout = 1'b0; mbusy = 1'b0; movf = 1'b0;
    run_op(OP_SHR, 0, 8'h00, 1'b0);

    // Randomized back-to-back ops with stalls against the model
    for (int r = 0; r < 80; r++) begin
      run_op(3'($urandom), int'($urandom_range(0, 15)), N'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
